fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage and IF/ID pipeline register for the pipelined CPU. Generates the PC, runs a single-outstanding request/response handshake with instruction memory, and presents the fetched instruction to decode, where the register file reads operands. Honours the register file's 2-bit `pause` hazard request by freezing IF/ID and buffering one returned instruction. Execute-stage redirects (taken branch/jump) flush IF/ID and restart fetch at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `pause`  in  2  hazard request from register file; 2'b00 = none, 2'b01 = rs, 2'b10 = rt, 2'b11 = both. Any nonzero value means stall.
- `redirect_valid`  in  1  taken branch/jump from execute.
- `redirect_pc`  in  32  redirect target; bits [1:0] forced to 0.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_ready`  in  1  request accepted this cycle when `imem_req` is high.
- `imem_rvalid`  in  1  response valid; arrives 1 or more cycles after acceptance.
- `imem_rdata`  in  32  instruction word.
- `id_valid`  out  1  IF/ID holds a real instruction.
- `id_instr`  out  32  IF/ID instruction.
- `id_pc`  out  32  IF/ID instruction address.
- `id_pc4`  out  32  `id_pc` + 4, modulo 2^32.

## Operation
- Registers: `pc` (next fetch address), `pc_inflight`, hold buffer (`hold_instr`, `hold_pc`), IF/ID outputs, state.
- States are IDLE, FETCH, WAIT, STALL and DROP.
- IDLE is the reset state. It lasts one cycle, then goes to FETCH. `imem_rvalid` is ignored in IDLE.
- FETCH drives `imem_req`=1 and `imem_addr`=`pc`. When `imem_ready` is high, `pc_inflight` <= `pc` and the state goes to WAIT.
- WAIT, on `imem_rvalid`:
  - If `pause`==0, load IF/ID with {1, `imem_rdata`, `pc_inflight`, `pc_inflight`+4}, set `pc` <= `pc_inflight`+4, and go to FETCH.
  - If `pause`!=0, capture the response into the hold buffer and go to STALL.
- STALL: on the first cycle with `pause`==0, load IF/ID from the hold buffer, set `pc` <= `hold_pc`+4, and go to FETCH.
- DROP: on `imem_rvalid`, discard the response and go to FETCH.
- Whenever `pause`!=0, IF/ID holds its value in every state. Pause is honoured even when `id_valid`=0.
- Redirect has highest priority and overrides `pause`. When `redirect_valid` is high:
  - `id_valid` <= 0, and `id_instr`/`id_pc`/`id_pc4` <= 0.
  - The hold buffer is discarded and `pc` <= {`redirect_pc`[31:2], 2'b00}.
  - Next state from FETCH without `imem_ready`: FETCH.
  - Next state from FETCH with `imem_ready`: DROP.
  - Next state from WAIT without `imem_rvalid`: DROP.
  - Next state from WAIT with `imem_rvalid`: FETCH, and the response is discarded.
  - Next state from STALL: FETCH.
  - Next state from DROP without `imem_rvalid`: DROP, with the new target.
  - Next state from DROP with `imem_rvalid`: FETCH.
  - Redirect in IDLE only updates `pc`.
- `imem_rvalid` outside WAIT/DROP is ignored.

## Timing
- Reset values, applied immediately on `rst` low: state IDLE, `pc`=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`, `id_valid`=0, `id_instr`=0, `id_pc`=0, `id_pc4`=0, hold buffer 0.
- Reset asserted mid-WAIT abandons the request. A stale `imem_rvalid` after reset release is ignored in IDLE.
- `imem_addr` must equal `pc` in every state.
- With `imem_ready`=1 and `imem_rvalid` one cycle after acceptance:
  - Request issued in cycle N.
  - Response in cycle N+1, with IF/ID updated at the end of N+1.
  - Next request issued in cycle N+2.
  - Throughput is one instruction per 2 cycles. This is intentional: only one request is ever outstanding.
- When `pause` is released in STALL, IF/ID updates at the end of that same cycle.
- A redirect makes `id_valid` low from the next cycle. The first request to the target is issued from the next cycle, or after DROP completes.

## Configuration
- `FETCH_PERF_EN` defined:
  - Adds output `perf_stall_cycles` (32-bit): counts cycles with `pause`!=0 while not in IDLE. Wraps at 2^32.
  - Adds output `perf_flushes` (16-bit): counts redirect cycles. Wraps at 2^16.
  - Both counters reset to 0.
- `FETCH_PERF_EN` undefined: neither port nor counter exists. Functional behaviour is identical.

## Test plan
- **Reset fetch.** Stimulus: reset release, `imem_ready`=1, memory returns `rdata`=addr^32'hA5A5_0000 one cycle after accept. Required: IF/ID shows `id_pc` 0x0, 0x4, 0x8 on every 2nd cycle, with matching `id_instr` and `id_pc4`.
- **Pause hold.** Stimulus: `pause`=2'b01 held 3 cycles while `id_pc`=0x8, and the 0xC response arrives during the pause. Required: `id_pc` stays 0x8 throughout. On the release cycle edge, `id_pc`=0xC and `id_instr`=0xA5A5_000C. The next request address is 0x10.
- **Redirect while waiting.** Stimulus: `redirect_valid`, `redirect_pc`=0x103 while in WAIT with `rvalid` delayed 2 cycles. Required: `id_valid`=0 next cycle, the late response is dropped, the next `imem_addr`=0x100, and then `id_pc`=0x100.
- **Redirect plus pause.** Stimulus: `redirect_valid`=1 together with `pause`=2'b11. Required: flush wins, `id_valid`=0, fetch restarts at the target.
- **Async reset mid-WAIT.** Stimulus: `rst` low mid-WAIT. Required: all outputs at reset values within the same cycle. A stray `imem_rvalid` in IDLE does not set `id_valid`.
- **Counters (`FETCH_PERF_EN`).** Stimulus: 3 pause cycles and 2 redirects. Required: `perf_stall_cycles`=3, `perf_flushes`=2.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and instruction memory (slave). Only one request is ever outstanding.
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input ready, rvalid, rdata);
  modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, single-outstanding imem handshake,
// pause hold buffer and redirect flush. Optional counters under `FETCH_PERF_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          pause,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  fetch_stage_if.master       imem,
  output logic                id_valid,
  output logic [31:0]         id_instr,
  output logic [31:0]         id_pc,
  output logic [31:0]         id_pc4
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_stall_cycles,
  output logic [15:0]         perf_flushes
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    STALL,
    DROP
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_inflight;
  logic [31:0] hold_instr;
  logic [31:0] hold_pc;
  logic        req_q;

  logic        stall;
  logic [31:0] target_pc;

  assign stall     = |pause;
  assign target_pc = redirect_pc & 32'hFFFF_FFFC;

  // The fetch address is the PC register itself, so it tracks pc in every state.
  assign imem.addr = pc;
  assign imem.req  = req_q;

  // NOTE: every register here, including the hold buffer, takes its reset value
  // asynchronously; state updates use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pc_inflight <= RESET_PC;
      hold_instr  <= '0;
      hold_pc     <= '0;
      req_q       <= 1'b0;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc4      <= '0;
    end else begin
      req_q <= 1'b0;

      if (redirect_valid) begin
        pc <= target_pc;
        if (state != IDLE) begin
          id_valid   <= 1'b0;
          id_instr   <= '0;
          id_pc      <= '0;
          id_pc4     <= '0;
          hold_instr <= '0;
          hold_pc    <= '0;
        end
        unique case (state)
          IDLE: begin
            state <= FETCH;
            req_q <= 1'b1;
          end
          FETCH: begin
            // An accepted request still owes us a response, which must be drained.
            if (imem.ready) begin
              state <= DROP;
            end else begin
              state <= FETCH;
              req_q <= 1'b1;
            end
          end
          WAIT: begin
            if (imem.rvalid) begin
              state <= FETCH;
              req_q <= 1'b1;
            end else begin
              state <= DROP;
            end
          end
          STALL: begin
            state <= FETCH;
            req_q <= 1'b1;
          end
          DROP: begin
            if (imem.rvalid) begin
              state <= FETCH;
              req_q <= 1'b1;
            end else begin
              state <= DROP;
            end
          end
          default: state <= IDLE;
        endcase
      end else begin
        unique case (state)
          IDLE: begin
            state <= FETCH;
            req_q <= 1'b1;
          end
          FETCH: begin
            if (imem.ready) begin
              pc_inflight <= pc;
              state       <= WAIT;
            end else begin
              req_q <= 1'b1;
            end
          end
          WAIT: begin
            if (imem.rvalid) begin
              if (!stall) begin
                id_valid <= 1'b1;
                id_instr <= imem.rdata;
                id_pc    <= pc_inflight;
                id_pc4   <= pc_inflight + 32'd4;
                pc       <= pc_inflight + 32'd4;
                state    <= FETCH;
                req_q    <= 1'b1;
              end else begin
                // Decode is frozen: park the instruction until the hazard clears.
                hold_instr <= imem.rdata;
                hold_pc    <= pc_inflight;
                state      <= STALL;
              end
            end
          end
          STALL: begin
            if (!stall) begin
              id_valid <= 1'b1;
              id_instr <= hold_instr;
              id_pc    <= hold_pc;
              id_pc4   <= hold_pc + 32'd4;
              pc       <= hold_pc + 32'd4;
              state    <= FETCH;
              req_q    <= 1'b1;
            end
          end
          DROP: begin
            if (imem.rvalid) begin
              state <= FETCH;
              req_q <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
    end else begin
      if (stall && state != IDLE) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (redirect_valid) begin
        perf_flushes <= perf_flushes + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-configurable imem responder plus a
// linear sequence of steps, each compared against hand-computed values.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [1:0]  pause;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flushes;
`endif

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .pause          (pause),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc4         (id_pc4)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: returns addr ^ 32'hA5A5_0000 'lat' cycles after acceptance.
  // It is deliberately not reset, so an abandoned request still answers.
  int          lat = 1;
  int          cnt = 0;
  logic        pending = 1'b0;
  logic [31:0] paddr = '0;

  always @(posedge clk) begin
    imem.rvalid <= 1'b0;
    if (pending) begin
      if (cnt <= 1) begin
        imem.rvalid <= 1'b1;
        imem.rdata  <= paddr ^ 32'hA5A5_0000;
        pending     <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end
    if (imem.req && imem.ready) begin
      if (lat <= 1) begin
        imem.rvalid <= 1'b1;
        imem.rdata  <= imem.addr ^ 32'hA5A5_0000;
      end else begin
        pending <= 1'b1;
        cnt     <= lat - 1;
        paddr   <= imem.addr;
      end
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst            = 1'b0;
    pause          = 2'b00;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem.ready     = 1'b1;

    // Reset values
    tick();
    check("rst_req",    {31'd0, imem.req}, 32'd0);
    check("rst_addr",   imem.addr,         32'h0);
    check("rst_valid",  {31'd0, id_valid}, 32'd0);
    check("rst_instr",  id_instr,          32'h0);
    check("rst_pc",     id_pc,             32'h0);
    check("rst_pc4",    id_pc4,            32'h0);
    rst = 1'b1;

    // Reset fetch: one instruction every 2 cycles
    tick(); // P1: IDLE -> FETCH
    check("p1_req",   {31'd0, imem.req}, 32'd1);
    check("p1_addr",  imem.addr,         32'h0);
    check("p1_valid", {31'd0, id_valid}, 32'd0);
    tick(); // P2: accepted, WAIT
    check("p2_req",   {31'd0, imem.req}, 32'd0);
    tick(); // P3: IF/ID <- 0x0
    check("f0_valid", {31'd0, id_valid}, 32'd1);
    check("f0_pc",    id_pc,             32'h0);
    check("f0_instr", id_instr,          32'hA5A5_0000);
    check("f0_pc4",   id_pc4,            32'h4);
    check("f0_addr",  imem.addr,         32'h4);
    check("f0_req",   {31'd0, imem.req}, 32'd1);
    tick(); // P4
    check("p4_pc_hold", id_pc, 32'h0);
    tick(); // P5: IF/ID <- 0x4
    check("f4_pc",    id_pc,    32'h4);
    check("f4_instr", id_instr, 32'hA5A5_0004);
    check("f4_pc4",   id_pc4,   32'h8);
    tick(); // P6
    tick(); // P7: IF/ID <- 0x8
    check("f8_pc",    id_pc,     32'h8);
    check("f8_instr", id_instr,  32'hA5A5_0008);
    check("f8_pc4",   id_pc4,    32'hC);
    check("f8_addr",  imem.addr, 32'hC);

    // Pause hold: 0xC fetched and returned while decode is frozen
    pause = 2'b01;
    tick(); // P8
    check("pz1_pc", id_pc, 32'h8);
    tick(); // P9: response parked
    check("pz2_pc", id_pc, 32'h8);
    check("pz2_instr", id_instr, 32'hA5A5_0008);
    tick(); // P10
    check("pz3_pc", id_pc, 32'h8);
    pause = 2'b00;
    tick(); // P11: released, IF/ID <- hold
    check("rel_pc",    id_pc,     32'hC);
    check("rel_instr", id_instr,  32'hA5A5_000C);
    check("rel_pc4",   id_pc4,    32'h10);
    check("rel_addr",  imem.addr, 32'h10);
    check("rel_req",   {31'd0, imem.req}, 32'd1);
`ifdef FETCH_PERF_EN
    check("perf_stall3", perf_stall_cycles, 32'd3);
`endif

    // Redirect while waiting, response delayed 2 cycles
    lat = 2;
    tick(); // P12: 0x10 accepted
    check("rw_wait_req", {31'd0, imem.req}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick(); // P13: -> DROP
    check("rw_valid", {31'd0, id_valid}, 32'd0);
    check("rw_pc",    id_pc,             32'h0);
    check("rw_instr", id_instr,          32'h0);
    check("rw_pc4",   id_pc4,            32'h0);
    check("rw_addr",  imem.addr,         32'h100);
    check("rw_req",   {31'd0, imem.req}, 32'd0);
    redirect_valid = 1'b0;
    tick(); // P14: late response dropped, -> FETCH
    check("rw_fetch_req",  {31'd0, imem.req}, 32'd1);
    check("rw_fetch_addr", imem.addr,         32'h100);
    check("rw_drop_valid", {31'd0, id_valid}, 32'd0);
    lat = 1;
    tick(); // P15
    check("rw_p15_valid", {31'd0, id_valid}, 32'd0);
    tick(); // P16: IF/ID <- 0x100
    check("rw_new_valid", {31'd0, id_valid}, 32'd1);
    check("rw_new_pc",    id_pc,             32'h100);
    check("rw_new_instr", id_instr,          32'hA5A5_0100);
    check("rw_new_pc4",   id_pc4,            32'h104);

    // Redirect together with pause=2'b11: flush wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    pause          = 2'b11;
    tick(); // P17: FETCH with ready -> DROP
    check("rp_valid", {31'd0, id_valid}, 32'd0);
    check("rp_pc",    id_pc,             32'h0);
    check("rp_addr",  imem.addr,         32'h200);
    check("rp_req",   {31'd0, imem.req}, 32'd0);
`ifdef FETCH_PERF_EN
    check("perf_flush2", {16'd0, perf_flushes}, 32'd2);
    check("perf_stall4", perf_stall_cycles,     32'd4);
`endif
    redirect_valid = 1'b0;
    pause          = 2'b00;
    tick(); // P18: drained, -> FETCH
    check("rp_fetch_req",  {31'd0, imem.req}, 32'd1);
    check("rp_fetch_addr", imem.addr,         32'h200);
    tick(); // P19
    tick(); // P20: IF/ID <- 0x200
    check("rp_new_pc",    id_pc,    32'h200);
    check("rp_new_instr", id_instr, 32'hA5A5_0200);
    check("rp_new_pc4",   id_pc4,   32'h204);

    // Memory not ready: request held at the same address
    imem.ready = 1'b0;
    tick(); // P21
    check("nr_req",  {31'd0, imem.req}, 32'd1);
    check("nr_addr", imem.addr,         32'h204);
    check("nr_pc",   id_pc,             32'h200);

    // Async reset mid-WAIT; the abandoned response lands while in IDLE
    imem.ready = 1'b1;
    lat        = 2;
    tick(); // P22: 0x204 accepted, WAIT
    check("ar_wait_req", {31'd0, imem.req}, 32'd0);
    #2 rst = 1'b0;
    #1;
    check("ar_valid", {31'd0, id_valid}, 32'd0);
    check("ar_instr", id_instr,          32'h0);
    check("ar_pc",    id_pc,             32'h0);
    check("ar_pc4",   id_pc4,            32'h0);
    check("ar_req",   {31'd0, imem.req}, 32'd0);
    check("ar_addr",  imem.addr,         32'h0);
`ifdef FETCH_PERF_EN
    check("ar_perf_stall", perf_stall_cycles,     32'd0);
    check("ar_perf_flush", {16'd0, perf_flushes}, 32'd0);
`endif
    tick(); // P23 (in reset): stale response scheduled
    rst = 1'b1;
    lat = 1;
    tick(); // P24: IDLE sees stale rvalid, ignores it
    check("ar_stale_valid", {31'd0, id_valid}, 32'd0);
    check("ar_stale_req",   {31'd0, imem.req}, 32'd1);
    check("ar_stale_addr",  imem.addr,         32'h0);
    tick(); // P25
    tick(); // P26: IF/ID <- 0x0
    check("ar_f0_valid", {31'd0, id_valid}, 32'd1);
    check("ar_f0_pc",    id_pc,             32'h0);
    check("ar_f0_instr", id_instr,          32'hA5A5_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Hard bound on the run in case the sequence stalls.
  initial begin
    #100000;
    $display("FAIL timeout: observed no completion, expected finish");
    $fatal(1, "timeout");
  end

endmodule
